// File: rtl/bram_sd_sync.sv
// Save-slot transfer sequencer: streams one slot's sectors between the save RAM and the HPS SD
// block interface, writes a default header on format, and tracks a dirty flag for autosave.
module bram_sd_sync #(
  parameter int unsigned SECTOR_LOG2 = 4,
  parameter int unsigned SLOTS_LOG2  = 2,
  parameter bit          AUTOSAVE    = 1'b0,
  parameter logic [63:0] FMT_INIT    = 64'h8010_8800_4D42_5548
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [SLOTS_LOG2-1:0] slot,
  input  logic                  load_req,
  input  logic                  save_req,
  input  logic                  format_req,
  input  logic                  autosave_tick,
  input  logic                  dirty_set,
  input  logic                  sd_ack,
  output logic [31:0]           sd_lba,
  output logic                  sd_rd,
  output logic                  sd_wr,
  output logic                  busy,
  output logic                  loading,
  output logic                  fmt_we,
  output logic [1:0]            fmt_addr,
  output logic [15:0]           fmt_data,
  output logic                  dirty,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_FMT  = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic        load_q_r, save_q_r, fmt_q_r, ack_q_r;
  logic        load_rise_s, save_rise_s, fmt_rise_s, ack_rise_s, ack_fall_s, auto_s;
  logic        start_load_s, start_save_s, start_fmt_s;
  logic [31:0] lba_start_s, lba_s;
  logic        rd_s, wr_s, busy_s, loading_s, we_s, dirty_s, done_s;
  logic [1:0]  addr_s;
  logic [15:0] data_s;

  function automatic logic [15:0] fmt_word(input logic [1:0] idx);
    fmt_word = FMT_INIT[{idx, 4'd0} +: 16];
  endfunction

  assign load_rise_s = load_req & ~load_q_r;
  assign save_rise_s = save_req & ~save_q_r;
  assign fmt_rise_s  = format_req & ~fmt_q_r;
  assign ack_rise_s  = sd_ack & ~ack_q_r;
  assign ack_fall_s  = ~sd_ack & ack_q_r;
  assign auto_s      = AUTOSAVE & dirty & autosave_tick;

  // Start arbitration: load beats save, save beats format, format beats autosave
  assign start_load_s = enable & load_rise_s;
  assign start_save_s = enable & ~load_rise_s & (save_rise_s | (~fmt_rise_s & auto_s));
  assign start_fmt_s  = enable & ~load_rise_s & ~save_rise_s & fmt_rise_s;

  // Next-state and next-output computation
  always_comb begin
    state_s   = state_r;
    lba_s     = sd_lba;
    rd_s      = sd_rd & ~ack_rise_s;
    wr_s      = sd_wr & ~ack_rise_s;
    busy_s    = busy;
    loading_s = loading;
    we_s      = 1'b0;
    addr_s    = fmt_addr;
    data_s    = fmt_data;
    dirty_s   = dirty;
    done_s    = 1'b0;
    lba_start_s = 32'd0;
    lba_start_s[SECTOR_LOG2 +: SLOTS_LOG2] = slot;
    case (state_r)
      ST_IDLE: begin
        if (start_load_s || start_save_s) begin
          state_s   = ST_XFER;
          lba_s     = lba_start_s;
          rd_s      = start_load_s;
          wr_s      = start_save_s;
          busy_s    = 1'b1;
          loading_s = start_load_s;
          dirty_s   = dirty & ~start_save_s;
        end else if (start_fmt_s) begin
          state_s = ST_FMT;
          busy_s  = 1'b1;
          we_s    = 1'b1;
          addr_s  = 2'd0;
          data_s  = fmt_word(2'd0);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (ack_fall_s) begin
          if (&sd_lba[SECTOR_LOG2-1:0]) begin
            state_s   = ST_IDLE;
            busy_s    = 1'b0;
            loading_s = 1'b0;
            done_s    = 1'b1;
          end else begin
            // direction is remembered by loading, which is only high for loads
            lba_s = sd_lba + 32'd1;
            rd_s  = loading;
            wr_s  = ~loading;
          end
        end else begin
          state_s = ST_XFER;
        end
      end
      ST_FMT: begin
        if (fmt_addr == 2'd3) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          dirty_s = 1'b1;
        end else begin
          we_s   = 1'b1;
          addr_s = fmt_addr + 2'd1;
          data_s = fmt_word(fmt_addr + 2'd1);
        end
      end
      default: begin
        state_s   = ST_IDLE;
        rd_s      = 1'b0;
        wr_s      = 1'b0;
        busy_s    = 1'b0;
        loading_s = 1'b0;
      end
    endcase
    dirty_s = dirty_s | dirty_set;
  end

  // State and output registers; edge detectors track inputs even during reset
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      sd_lba   <= 32'd0;
      sd_rd    <= 1'b0;
      sd_wr    <= 1'b0;
      busy     <= 1'b0;
      loading  <= 1'b0;
      fmt_we   <= 1'b0;
      fmt_addr <= 2'd0;
      fmt_data <= 16'd0;
      dirty    <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_r  <= state_s;
      sd_lba   <= lba_s;
      sd_rd    <= rd_s;
      sd_wr    <= wr_s;
      busy     <= busy_s;
      loading  <= loading_s;
      fmt_we   <= we_s;
      fmt_addr <= addr_s;
      fmt_data <= data_s;
      dirty    <= dirty_s;
      done     <= done_s;
    end
    load_q_r <= load_req;
    save_q_r <= save_req;
    fmt_q_r  <= format_req;
    ack_q_r  <= sd_ack;
  end

endmodule
